// File: rtl/clkctrl_divsel.sv
// Glitch-free CPU clock generator: even division of hsclk_in or retimed lsclk_in, switched only after clkout falls.
// Optional macro CLKCTRL_STRETCH_EN adds clk_stretch to defer the HS rising edge.
module clkctrl_divsel #(
  parameter int DIV_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 4
) (
  input  logic             hsclk_in,
  input  logic             rst_b,
  input  logic             lsclk_in,
  input  logic             hsclk_sel,
  input  logic [DIV_W-1:0] cpuclk_div_sel,
`ifdef CLKCTRL_STRETCH_EN
  input  logic             clk_stretch,
`endif
  output logic             clkout,
  output logic             hsclk_selected,
  output logic             lsclk_selected
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_LSWAIT = 4'b0001,
    S_LS     = 4'b0010,
    S_GAP    = 4'b0100,
    S_HS     = 4'b1000
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_clkout;
  logic                   w_clkout_nxt;
  logic [DIV_W-1:0]       r_cnt;
  logic [DIV_W-1:0]       w_cnt_nxt;
  logic [DIV_W-1:0]       r_div_q;
  logic [DIV_W-1:0]       w_div_q_nxt;
  logic [GAP_W-1:0]       r_gap;
  logic [GAP_W-1:0]       w_gap_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hs_sel;
  logic                   r_ls_sel;
  logic                   w_ls_sync;
  logic                   w_stretch;
  logic                   w_gap_done;
  logic                   w_hs_tick;
  logic                   w_hs_fall;

`ifdef CLKCTRL_STRETCH_EN
  assign w_stretch = clk_stretch;
`else
  assign w_stretch = 1'b0;
`endif

  assign w_ls_sync  = r_sync[SYNC_STAGES-1];
  assign w_gap_done = (r_gap == GAP_W'(GAP_CYCLES - 1));
  // Stretch only holds the end of a low phase; high phases always run to length.
  assign w_hs_tick  = (r_cnt == r_div_q) && !(!r_clkout && w_stretch);
  assign w_hs_fall  = w_hs_tick && r_clkout;

  // State, datapath and output flops; reset forces clkout low immediately.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= S_LSWAIT;
      r_clkout <= 1'b0;
      r_cnt    <= {DIV_W{1'b0}};
      r_div_q  <= {DIV_W{1'b0}};
      r_gap    <= {GAP_W{1'b0}};
      r_sync   <= {SYNC_STAGES{1'b0}};
      r_hs_sel <= 1'b0;
      r_ls_sel <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_clkout <= w_clkout_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div_q  <= w_div_q_nxt;
      r_gap    <= w_gap_nxt;
      r_sync   <= {r_sync[SYNC_STAGES-2:0], lsclk_in};
      r_hs_sel <= (w_state_nxt == S_HS);
      r_ls_sel <= (w_state_nxt == S_LS) || (w_state_nxt == S_LSWAIT);
    end
  end

  // Next-state selection; source changes only leave LS/HS on a falling clkout edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LSWAIT: begin
        if (hsclk_sel)       w_state_nxt = S_GAP;
        else if (!w_ls_sync) w_state_nxt = S_LS;
        else                 w_state_nxt = S_LSWAIT;
      end
      S_LS: begin
        if (r_clkout && !w_ls_sync && hsclk_sel) w_state_nxt = S_GAP;
        else                                     w_state_nxt = S_LS;
      end
      S_GAP: begin
        if (w_gap_done) w_state_nxt = hsclk_sel ? S_HS : S_LSWAIT;
        else            w_state_nxt = S_GAP;
      end
      S_HS: begin
        if (w_hs_fall && !hsclk_sel) w_state_nxt = S_GAP;
        else                         w_state_nxt = S_HS;
      end
      default: w_state_nxt = S_LSWAIT;
    endcase
  end

  // Next clkout, phase counter, latched ratio and gap counter.
  always_comb begin
    w_clkout_nxt = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_div_q_nxt  = r_div_q;
    w_gap_nxt    = {GAP_W{1'b0}};
    case (r_state)
      S_LSWAIT: begin
        w_clkout_nxt = 1'b0;
        w_cnt_nxt    = {DIV_W{1'b0}};
      end
      S_LS: begin
        w_clkout_nxt = w_ls_sync;
        w_cnt_nxt    = {DIV_W{1'b0}};
      end
      S_GAP: begin
        w_clkout_nxt = 1'b0;
        w_cnt_nxt    = {DIV_W{1'b0}};
        if (w_gap_done) begin
          w_gap_nxt   = {GAP_W{1'b0}};
          w_div_q_nxt = cpuclk_div_sel;
        end else begin
          w_gap_nxt   = r_gap + {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end
      S_HS: begin
        if (w_hs_tick) begin
          w_clkout_nxt = ~r_clkout;
          w_cnt_nxt    = {DIV_W{1'b0}};
          if (w_hs_fall && hsclk_sel) w_div_q_nxt = cpuclk_div_sel;
          else                        w_div_q_nxt = r_div_q;
        end else begin
          w_clkout_nxt = r_clkout;
          if (r_cnt == r_div_q) w_cnt_nxt = r_cnt;
          else                  w_cnt_nxt = r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_clkout_nxt = 1'b0;
        w_cnt_nxt    = {DIV_W{1'b0}};
      end
    endcase
  end

  assign clkout         = r_clkout;
  assign hsclk_selected = r_hs_sel;
  assign lsclk_selected = r_ls_sel;

endmodule

// File: tb/tb_clkctrl_divsel.sv
// Self-checking bench for clkctrl_divsel: directed scenarios plus random traffic against a cycle reference model.
// Stretch scenario is compiled only when CLKCTRL_STRETCH_EN is defined.
module tb_clkctrl_divsel;

  localparam int DIV_W       = 2;
  localparam int SYNC_STAGES = 2;
  localparam int GAP_CYCLES  = 4;
  localparam int M_LSWAIT = 0, M_LS = 1, M_GAP = 2, M_HS = 3;

  logic             hsclk_in = 1'b0;
  logic             rst_b = 1'b0;
  logic             lsclk_in = 1'b0;
  logic             hsclk_sel = 1'b0;
  logic [DIV_W-1:0] cpuclk_div_sel = '0;
`ifdef CLKCTRL_STRETCH_EN
  logic             clk_stretch = 1'b0;
`endif
  logic             clkout;
  logic             hsclk_selected;
  logic             lsclk_selected;

  clkctrl_divsel #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES), .GAP_CYCLES(GAP_CYCLES)) dut (
    .hsclk_in       (hsclk_in),
    .rst_b          (rst_b),
    .lsclk_in       (lsclk_in),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
`ifdef CLKCTRL_STRETCH_EN
    .clk_stretch    (clk_stretch),
`endif
    .clkout         (clkout),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected)
  );

  always #5 hsclk_in = ~hsclk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int ls_half  = 8;
  int ls_cnt   = 0;
  int cyc_idx  = 0;
  int ls_rise_idx = 0;

  // Reference model state
  int m_sync [SYNC_STAGES];
  int m_state, m_clk, m_cnt, m_div, m_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 0;
    m_state = M_LSWAIT; m_clk = 0; m_cnt = 0; m_div = 0; m_gap = 0;
  endtask

  task automatic model_step();
    int ls;
    int st;
    ls = m_sync[SYNC_STAGES-1];
    for (int i = SYNC_STAGES-1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = int'(lsclk_in);
    st = 0;
`ifdef CLKCTRL_STRETCH_EN
    st = int'(clk_stretch);
`endif
    case (m_state)
      M_LSWAIT: begin
        m_clk = 0;
        if (hsclk_sel) begin m_state = M_GAP; m_gap = 0; end
        else if (ls == 0) m_state = M_LS;
      end
      M_LS: begin
        if (m_clk == 1 && ls == 0 && hsclk_sel) begin m_clk = 0; m_state = M_GAP; m_gap = 0; end
        else m_clk = ls;
      end
      M_GAP: begin
        m_clk = 0;
        m_gap++;
        if (m_gap == GAP_CYCLES) begin
          m_state = hsclk_sel ? M_HS : M_LSWAIT;
          m_cnt = 0;
          m_div = int'(cpuclk_div_sel);
        end
      end
      default: begin
        if (m_cnt == m_div && !(m_clk == 0 && st == 1)) begin
          m_cnt = 0;
          if (m_clk == 1) begin
            m_clk = 0;
            if (!hsclk_sel) begin m_state = M_GAP; m_gap = 0; end
            else m_div = int'(cpuclk_div_sel);
          end else m_clk = 1;
        end else if (m_cnt < m_div) m_cnt++;
      end
    endcase
  endtask

  // One hsclk cycle: advance lsclk, step the model, then compare at the falling edge.
  task automatic cyc();
    if (ls_cnt >= ls_half - 1) begin
      lsclk_in = ~lsclk_in;
      ls_cnt = 0;
      if (lsclk_in) ls_rise_idx = cyc_idx + 1;
    end else ls_cnt++;
    if (!rst_b) model_reset(); else model_step();
    @(posedge hsclk_in);
    @(negedge hsclk_in);
    cyc_idx++;
    chk("clkout", {31'd0, clkout}, m_clk);
    chk("hs_selected", {31'd0, hsclk_selected}, (m_state == M_HS) ? 32'd1 : 32'd0);
    chk("ls_selected", {31'd0, lsclk_selected},
        (m_state == M_LS || m_state == M_LSWAIT) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_val(input logic v, input int max, output int n);
    n = 0;
    do begin cyc(); n++; end while (clkout !== v && n < max);
    if (clkout !== v) chk("wait_timeout", {31'd0, clkout}, {31'd0, v});
  endtask

  int n;
  int k;

  initial begin
    model_reset();
    @(negedge hsclk_in);
    #1;
    chk("rst_clkout", {31'd0, clkout}, 32'd0);
    chk("rst_ls_sel", {31'd0, lsclk_selected}, 32'd1);
    chk("rst_hs_sel", {31'd0, hsclk_selected}, 32'd0);
    cyc(); cyc();
    rst_b = 1'b1;

    // LS follow: 8 high / 8 low, three edges of latency
    repeat (40) cyc();
    wait_val(1'b0, 40, n);
    wait_val(1'b1, 40, n);
    chk("ls_latency", cyc_idx - ls_rise_idx + 1, 32'd3);
    wait_val(1'b0, 40, n);
    chk("ls_high_len", n, 32'd8);
    wait_val(1'b1, 40, n);
    chk("ls_low_len", n, 32'd8);

    // LS -> HS at div 0
    hsclk_sel = 1'b1;
    cpuclk_div_sel = 2'd0;
    wait_val(1'b0, 40, n);
    wait_val(1'b1, 40, n);
    chk("gap_low_len", n, 32'd5);
    chk("hs_after_gap", {31'd0, hsclk_selected}, 32'd1);
    wait_val(1'b0, 10, n); chk("div0_high", n, 32'd1);
    wait_val(1'b1, 10, n); chk("div0_low", n, 32'd1);

    // Ratio change while high, then a change mid low phase
    cpuclk_div_sel = 2'd3;
    wait_val(1'b0, 10, n); chk("ratio_cur_high", n, 32'd1);
    wait_val(1'b1, 10, n); chk("div3_low", n, 32'd4);
    wait_val(1'b0, 10, n); chk("div3_high", n, 32'd4);
    cpuclk_div_sel = 2'd1;
    wait_val(1'b1, 10, n); chk("midlow_ignored", n, 32'd4);
    wait_val(1'b0, 10, n); chk("midlow_high", n, 32'd4);
    wait_val(1'b1, 10, n); chk("div1_low", n, 32'd2);
    wait_val(1'b0, 10, n); chk("div1_high", n, 32'd2);

`ifdef CLKCTRL_STRETCH_EN
    cyc();
    clk_stretch = 1'b1;
    repeat (5) cyc();
    clk_stretch = 1'b0;
    wait_val(1'b1, 10, n); chk("stretch_low_tail", n, 32'd1);
    wait_val(1'b0, 10, n); chk("stretch_high", n, 32'd2);
`endif

    // HS -> LS requested during the second high cycle of a div-3 phase
    cpuclk_div_sel = 2'd3;
    wait_val(1'b1, 10, n); chk("pre_hsls_low", n, 32'd2);
    wait_val(1'b0, 10, n);
    wait_val(1'b1, 10, n); chk("hsls_div3_low", n, 32'd4);
    cyc();
    hsclk_sel = 1'b0;
    wait_val(1'b0, 10, n); chk("hsls_high_rest", n, 32'd3);
    wait_val(1'b1, 60, n);
    chk("hsls_low_ge_gap", (n > GAP_CYCLES) ? 32'd1 : 32'd0, 32'd1);
    chk("hsls_ls_sel", {31'd0, lsclk_selected}, 32'd1);

    // Gap reversal: 1 -> 0 -> 1 inside the gap returns to HS
    hsclk_sel = 1'b1;
    k = 0;
    while (lsclk_selected === 1'b1 && k < 60) begin cyc(); k++; end
    chk("enter_gap", {31'd0, lsclk_selected}, 32'd0);
    hsclk_sel = 1'b0; cyc();
    hsclk_sel = 1'b1; cyc();
    wait_val(1'b1, 20, n);
    chk("gap_reversal_len", n, 32'd6);
    chk("gap_reversal_hs", {31'd0, hsclk_selected}, 32'd1);

    // Reset while HS clkout is high
    rst_b = 1'b0;
    #1;
    chk("midrst_clkout", {31'd0, clkout}, 32'd0);
    chk("midrst_hs_sel", {31'd0, hsclk_selected}, 32'd0);
    chk("midrst_ls_sel", {31'd0, lsclk_selected}, 32'd1);
    model_reset();
    cyc(); cyc();
    rst_b = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) hsclk_sel = ~hsclk_sel;
      if ($urandom_range(0, 14) == 0) cpuclk_div_sel = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) ls_half = $urandom_range(2, 10);
      if ($urandom_range(0, 399) == 0) begin
        rst_b = 1'b0;
        cyc(); cyc();
        rst_b = 1'b1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
